// File: rtl/pwm_ramp_seq_pkg.sv
// rtl/pwm_ramp_seq_pkg.sv - shared states, widths and duty step helper for the PWM ramp sequencer
package pwm_ramp_seq_pkg;

    localparam int DUTY_W = 3;
    localparam int DIV_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STAGGER   = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    // One LSB toward the target, holding once it is reached.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        if (cur < tgt)
            return cur + DUTY_W'(1);
        else if (cur > tgt)
            return cur - DUTY_W'(1);
        else
            return cur;
    endfunction

endpackage

// File: rtl/pwm_ramp_seq_if.sv
// rtl/pwm_ramp_seq_if.sv - control-side and PWM-bank-side signal bundle of the ramp sequencer
interface pwm_ramp_seq_if
    import pwm_ramp_seq_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int RAMP_W = 16,
    parameter int STAG_W = 8
);
    logic                     start;
    logic                     stop;
    logic                     fault;
    logic                     clr_fault;
    logic [DUTY_W*N_CH-1:0]   target_duty;
    logic [RAMP_W-1:0]        ramp_period;
    logic [STAG_W-1:0]        stagger;
    logic [DIV_W-1:0]         cfg_div;
    logic [N_CH-1:0]          pwm_en;
    logic [DUTY_W*N_CH-1:0]   pwm_duty;
    logic [DIV_W-1:0]         pwm_div;
    logic                     busy;
    logic                     done;
    logic                     fault_flag;

    modport master (
        output start, stop, fault, clr_fault, target_duty, ramp_period, stagger, cfg_div,
        input  pwm_en, pwm_duty, pwm_div, busy, done, fault_flag
    );

    modport slave (
        input  start, stop, fault, clr_fault, target_duty, ramp_period, stagger, cfg_div,
        output pwm_en, pwm_duty, pwm_div, busy, done, fault_flag
    );
endinterface

// File: rtl/ramp_tick_gen.sv
// rtl/ramp_tick_gen.sv - duty step interval counter, one tick every max(period,1) cycles
module ramp_tick_gen #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] period,
    output logic         tick
);
    logic [W-1:0] cnt;
    logic [W-1:0] last;

    // Compare-and-clear rather than wrap, so a shortened period takes effect at once.
    assign last = (period == '0) ? '0 : period - W'(1);
    assign tick = (cnt >= last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/pwm_ramp_seq.sv
// rtl/pwm_ramp_seq.sv - staggered enable, soft-start/stop duty ramp and fault shutdown for a PWM bank
module pwm_ramp_seq
    import pwm_ramp_seq_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int RAMP_W = 16,
    parameter int STAG_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_ramp_seq_if.slave bus
);
    localparam int CH_W = $clog2(N_CH + 1);

    seq_state_t                   state, state_next;
    logic [N_CH-1:0]              en_q, en_next;
    logic [N_CH-1:0][DUTY_W-1:0]  duty_q, duty_next;
    logic [N_CH-1:0][DUTY_W-1:0]  shadow_q, shadow_next;
    logic [N_CH-1:0][DUTY_W-1:0]  toward, lower;
    logic [DIV_W-1:0]             div_q, div_next;
    logic                         done_q, done_next;
    logic                         busy_q, flag_q;
    logic [CH_W-1:0]              ch_idx, ch_idx_next;
    logic [STAG_W-1:0]            stag_cnt, stag_next;
    logic                         tick;
    logic                         tick_clear;

    assign tick_clear = (state_next != state);

    ramp_tick_gen #(.W(RAMP_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (tick_clear),
        .period (bus.ramp_period),
        .tick   (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign toward[i] = step_toward(duty_q[i], shadow_q[i]);
        assign lower[i]  = (duty_q[i] != '0) ? duty_q[i] - DUTY_W'(1) : '0;
    end

    always_comb begin
        state_next  = state;
        en_next     = en_q;
        duty_next   = duty_q;
        shadow_next = shadow_q;
        div_next    = div_q;
        done_next   = 1'b0;
        ch_idx_next = ch_idx;
        stag_next   = stag_cnt;

        if (bus.fault) begin
            state_next = ST_FAULT;
            en_next    = '0;
            duty_next  = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_next  = ST_STAGGER;
                        shadow_next = bus.target_duty;
                        div_next    = bus.cfg_div;
                        stag_next   = '0;
                        if (bus.stagger == '0) begin
                            en_next     = '1;
                            ch_idx_next = CH_W'(N_CH);
                        end else begin
                            en_next     = N_CH'(1);
                            ch_idx_next = CH_W'(1);
                        end
                    end
                end
                ST_STAGGER: begin
                    if (bus.stop) begin
                        state_next = ST_RAMP_DOWN;
                    end else if (ch_idx == CH_W'(N_CH)) begin
                        state_next = ST_RAMP_UP;
                    end else if (bus.stagger == '0 || stag_cnt >= bus.stagger - STAG_W'(1)) begin
                        for (int i = 0; i < N_CH; i++)
                            if (CH_W'(i) == ch_idx)
                                en_next[i] = 1'b1;
                        ch_idx_next = ch_idx + CH_W'(1);
                        stag_next   = '0;
                    end else begin
                        stag_next = stag_cnt + STAG_W'(1);
                    end
                end
                ST_RAMP_UP: begin
                    if (bus.stop) begin
                        state_next = ST_RAMP_DOWN;
                    end else if (tick) begin
                        duty_next = toward;
                        if (toward == shadow_q) begin
                            state_next = ST_HOLD;
                            done_next  = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.stop) begin
                        state_next = ST_RAMP_DOWN;
                    end else if (bus.start) begin
                        state_next  = ST_RAMP_UP;
                        shadow_next = bus.target_duty;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (tick) begin
                        duty_next = lower;
                        if (lower == '0) begin
                            en_next    = '0;
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_FAULT: begin
                    if (bus.clr_fault)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            en_q     <= '0;
            duty_q   <= '0;
            shadow_q <= '0;
            div_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            flag_q   <= 1'b0;
            ch_idx   <= '0;
            stag_cnt <= '0;
        end else begin
            state    <= state_next;
            en_q     <= en_next;
            duty_q   <= duty_next;
            shadow_q <= shadow_next;
            div_q    <= div_next;
            done_q   <= done_next;
            busy_q   <= (state_next != ST_IDLE) && (state_next != ST_FAULT);
            flag_q   <= (state_next == ST_FAULT);
            ch_idx   <= ch_idx_next;
            stag_cnt <= stag_next;
        end
    end

    assign bus.pwm_en     = en_q;
    assign bus.pwm_duty   = duty_q;
    assign bus.pwm_div    = div_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fault_flag = flag_q;
endmodule

// File: tb/tb_pwm_ramp_seq.sv
// tb/tb_pwm_ramp_seq.sv - directed bench for pwm_ramp_seq with hand-computed expectations
module tb_pwm_ramp_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pwm_ramp_seq_if #(.N_CH(4), .RAMP_W(16), .STAG_W(8)) bus ();

    pwm_ramp_seq #(.N_CH(4), .RAMP_W(16), .STAG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.fault       = 1'b0;
        bus.clr_fault   = 1'b0;
        bus.target_duty = 12'h067;
        bus.ramp_period = 16'd4;
        bus.stagger     = 8'd2;
        bus.cfg_div     = 3'd5;

        step(3);
        chk("rst_en",   32'(bus.pwm_en),     32'h0);
        chk("rst_duty", 32'(bus.pwm_duty),   32'h0);
        chk("rst_div",  32'(bus.pwm_div),    32'h0);
        chk("rst_busy", 32'(bus.busy),       32'h0);
        chk("rst_done", 32'(bus.done),       32'h0);
        chk("rst_flag", 32'(bus.fault_flag), 32'h0);
        rst = 1'b0;
        step(2);

        // Soft start: targets ch0..ch3 = 7,4,1,0, stagger 2, period 4
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("a1_en",   32'(bus.pwm_en),   32'h1);
        chk("a1_busy", 32'(bus.busy),     32'h1);
        chk("a1_div",  32'(bus.pwm_div),  32'h5);
        chk("a1_duty", 32'(bus.pwm_duty), 32'h0);
        bus.cfg_div = 3'd2;
        step(1);  chk("a2_en", 32'(bus.pwm_en), 32'h1);
        step(1);  chk("a3_en", 32'(bus.pwm_en), 32'h3);
        step(2);  chk("a5_en", 32'(bus.pwm_en), 32'h7);
        step(2);  chk("a7_en", 32'(bus.pwm_en), 32'hF);
        step(1);  chk("a8_duty", 32'(bus.pwm_duty), 32'h0);
        step(3);  chk("a11_duty", 32'(bus.pwm_duty), 32'h0);
        step(1);  chk("a12_duty", 32'(bus.pwm_duty), 32'h049);
        step(23);
        chk("a35_duty", 32'(bus.pwm_duty), 32'h066);
        chk("a35_done", 32'(bus.done),     32'h0);
        step(1);
        chk("a36_duty", 32'(bus.pwm_duty), 32'h067);
        chk("a36_done", 32'(bus.done),     32'h1);
        step(1);
        chk("a37_done", 32'(bus.done),     32'h0);
        chk("a37_busy", 32'(bus.busy),     32'h1);
        step(3);

        // Retarget from HOLD: ch0 7->2, ch1 4->6
        bus.target_duty = 12'h072;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("b1_duty", 32'(bus.pwm_duty), 32'h067);
        step(4);  chk("b5_duty", 32'(bus.pwm_duty), 32'h06E);
        step(12);
        chk("b17_duty", 32'(bus.pwm_duty), 32'h073);
        chk("b17_done", 32'(bus.done),     32'h0);
        step(4);
        chk("b21_duty", 32'(bus.pwm_duty), 32'h072);
        chk("b21_done", 32'(bus.done),     32'h1);
        chk("b21_en",   32'(bus.pwm_en),   32'hF);
        chk("b21_div",  32'(bus.pwm_div),  32'h5);
        step(2);

        // stop and start together in HOLD: stop wins, targets not recaptured
        bus.target_duty = 12'hFFF;
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        chk("c1_busy", 32'(bus.busy),     32'h1);
        step(4);  chk("c5_duty", 32'(bus.pwm_duty), 32'h029);
        step(16);
        chk("c21_duty", 32'(bus.pwm_duty), 32'h008);
        chk("c21_en",   32'(bus.pwm_en),   32'hF);
        step(4);
        chk("c25_duty", 32'(bus.pwm_duty), 32'h0);
        chk("c25_en",   32'(bus.pwm_en),   32'h0);
        chk("c25_done", 32'(bus.done),     32'h1);
        chk("c25_busy", 32'(bus.busy),     32'h0);
        step(1);
        chk("c26_done", 32'(bus.done),     32'h0);

        // stagger 0, period 0, then fault mid ramp-up
        bus.target_duty = 12'h067;
        bus.stagger     = 8'd0;
        bus.ramp_period = 16'd0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("d1_en",  32'(bus.pwm_en),  32'hF);
        chk("d1_div", 32'(bus.pwm_div), 32'h2);
        step(2);  chk("d3_duty", 32'(bus.pwm_duty), 32'h049);
        step(1);  chk("d4_duty", 32'(bus.pwm_duty), 32'h052);
        bus.fault = 1'b1;
        step(1);
        chk("d5_en",   32'(bus.pwm_en),     32'h0);
        chk("d5_duty", 32'(bus.pwm_duty),   32'h0);
        chk("d5_flag", 32'(bus.fault_flag), 32'h1);
        chk("d5_busy", 32'(bus.busy),       32'h0);
        bus.clr_fault = 1'b1;
        step(1);
        chk("d6_flag", 32'(bus.fault_flag), 32'h1);
        bus.clr_fault = 1'b0;
        bus.fault = 1'b0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("d7_flag", 32'(bus.fault_flag), 32'h1);
        chk("d7_busy", 32'(bus.busy),       32'h0);
        bus.clr_fault = 1'b1;
        step(1);
        bus.clr_fault = 1'b0;
        chk("d8_flag", 32'(bus.fault_flag), 32'h0);
        chk("d8_busy", 32'(bus.busy),       32'h0);

        // fault and stop together in HOLD: fault wins
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(8);
        chk("e9_duty", 32'(bus.pwm_duty), 32'h067);
        chk("e9_done", 32'(bus.done),     32'h1);
        step(1);
        bus.stop  = 1'b1;
        bus.fault = 1'b1;
        step(1);
        bus.stop  = 1'b0;
        bus.fault = 1'b0;
        chk("e11_flag", 32'(bus.fault_flag), 32'h1);
        chk("e11_en",   32'(bus.pwm_en),     32'h0);
        bus.clr_fault = 1'b1;
        step(1);
        bus.clr_fault = 1'b0;
        chk("e12_flag", 32'(bus.fault_flag), 32'h0);

        // async reset in the middle of ramp-down
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(9);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        step(1);
        chk("f12_duty", 32'(bus.pwm_duty), 32'h01E);
        chk("f12_en",   32'(bus.pwm_en),   32'hF);
        #1 rst = 1'b1;
        #1;
        chk("f_rst_en",   32'(bus.pwm_en),   32'h0);
        chk("f_rst_duty", 32'(bus.pwm_duty), 32'h0);
        chk("f_rst_div",  32'(bus.pwm_div),  32'h0);
        chk("f_rst_busy", 32'(bus.busy),     32'h0);
        step(2);
        rst = 1'b0;
        step(2);
        chk("f_idle_busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
